// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and helpers for the FIFO-to-UART transmit path.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Level driven on the serial line whenever no frame is in flight.
    localparam logic TX_IDLE_LEVEL = 1'b1;

    // Widest word calc_parity accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PARITY_MAX_BITS = 64;

    // Even parity is the plain XOR of the data; odd parity inverts it.
    function automatic logic calc_parity(input logic [PARITY_MAX_BITS-1:0] data,
                                         input logic                       odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by the drain stage (master) and the FIFO (slave).
interface fifo_uart_tx_if #(
    parameter int DWIDTH = 7
) ();

    logic              fifo_empty;
    logic [DWIDTH:0]   fifo_dout;
    logic              fifo_rd_en;

    // Drain stage: issues read requests, consumes flag and data.
    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_dout
    );

    // FIFO: honours read requests, supplies flag and data.
    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_dout
    );

endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 and wraps. tick marks the last
// cycle of a bit time, pre_tick the cycle before it. Shared with the RX stage.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next count: synchronous clear wins, otherwise wrap at LAST.
    // NOTE: every path assigns cnt_d (default first), so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    // NOTE: state flops use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = (cnt_q == LAST);
    assign pre_tick = (cnt_q == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one word at a time and serialises each word LSB-first
// as start bit, data, optional parity and one or two stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DWIDTH       = 7,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int            BW       = $clog2(DWIDTH + 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH);

    tx_state_t       state_d,    state_q;
    logic [DWIDTH:0] shift_d,    shift_q;
    logic [BW-1:0]   bit_cnt_d,  bit_cnt_q;
    logic            stop_cnt_d, stop_cnt_q;
    logic            parity_d,   parity_q;
    logic            tx_d,       tx_q;
    logic            rd_en_d,    rd_en_q;
    logic            busy_d,     busy_q;
    logic            done_d,     done_q;

    logic baud_clear;
    logic baud_tick;
    logic baud_pre_tick;
    logic can_fetch;
    logic last_stop;

    // The bit timer restarts in WAIT so START always gets a full bit time.
    assign baud_clear = (state_q == WAIT);
    assign can_fetch  = enable && !fifo.fifo_empty;
    assign last_stop  = (STOP_BITS == 1) || stop_cnt_q;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (baud_clear),
        .tick     (baud_tick),
        .pre_tick (baud_pre_tick)
    );

    // Frame sequencer: next state plus the next value of every registered output.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = TX_IDLE_LEVEL;
                if (can_fetch) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // FIFO data is valid this cycle; capture it and drop the line.
                shift_d    = fifo.fifo_dout;
                parity_d   = calc_parity(PARITY_MAX_BITS'(fifo.fifo_dout), PARITY_ODD != 0);
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                tx_d       = 1'b0;
                state_d    = START;
            end
            START: begin
                if (baud_tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = TX_IDLE_LEVEL;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    tx_d    = TX_IDLE_LEVEL;
                    state_d = STOP;
                end
            end
            STOP: begin
                // Raised one cycle early so the registered pulse lands on the last cycle.
                done_d = last_stop && baud_pre_tick;
                if (baud_tick) begin
                    if (!last_stop) begin
                        stop_cnt_d = 1'b1;
                    end else if (can_fetch) begin
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = TX_IDLE_LEVEL;
                state_d = IDLE;
            end
        endcase

        // FETCH is always followed by WAIT, so the read request is a single-cycle pulse.
        rd_en_d = (state_d == FETCH);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers.
    // NOTE: the shift register is a plain datapath register and is cleared on reset like the rest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= TX_IDLE_LEVEL;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fifo.fifo_rd_en = rd_en_q;
    assign tx              = tx_q;
    assign busy            = busy_q;
    assign frame_done      = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx. dut_a: 8N1, dut_b: 8O2, both 4 clk per bit.
// A FIFO model per DUT pops on the falling edge during the read-request cycle,
// so data is valid in the following cycle.
module tb_fifo_uart_tx;

    logic clk;
    logic rst;
    logic en_a, en_b;
    logic tx_a, busy_a, fd_a;
    logic tx_b, busy_b, fd_b;

    fifo_uart_tx_if #(.DWIDTH(7)) if_a ();
    fifo_uart_tx_if #(.DWIDTH(7)) if_b ();

    fifo_uart_tx #(
        .DWIDTH(7), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .fifo(if_a),
        .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
    );

    fifo_uart_tx #(
        .DWIDTH(7), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .fifo(if_b),
        .tx(tx_b), .busy(busy_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rd_cnt_a = 0, rd_cnt_b = 0;
    int         last_rd_a = 0, last_rd_b = 0;
    logic       prev_rd_a = 1'b0, prev_rd_b = 1'b0;
    int         rd_consec = 0;
    int         underflow = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int         last_fall = 0;
    int         last_fd = 0;
    int         prev_fd = 0;
    logic       obs_bits [0:15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction

    function automatic logic get_fd(input int sel);
        return (sel != 0) ? fd_b : fd_a;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    // Expected line level for bit slot idx of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int pe, input int odd, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (pe != 0 && idx == 9) return (^d) ^ (odd != 0);
        return 1'b1;
    endfunction

    task automatic push_a(input logic [7:0] d);
        q_a.push_back(d);
        if_a.fifo_empty = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        q_b.push_back(d);
        if_b.fifo_empty = 1'b0;
    endtask

    // Advance to the next falling edge and run both FIFO models.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (if_a.fifo_rd_en === 1'b1) begin
            rd_cnt_a++;
            last_rd_a = cyc;
            if (prev_rd_a) rd_consec++;
            if (q_a.size() == 0) underflow++;
            else if_a.fifo_dout = q_a.pop_front();
        end
        prev_rd_a = if_a.fifo_rd_en;
        if_a.fifo_empty = (q_a.size() == 0);
        if (if_b.fifo_rd_en === 1'b1) begin
            rd_cnt_b++;
            last_rd_b = cyc;
            if (prev_rd_b) rd_consec++;
            if (q_b.size() == 0) underflow++;
            else if_b.fifo_dout = q_b.pop_front();
        end
        prev_rd_b = if_b.fifo_rd_en;
        if_b.fifo_empty = (q_b.size() == 0);
    endtask

    // Wait (bounded) for the start bit, then check every cycle of the frame.
    task automatic check_frame(input int sel, input logic [7:0] d, input int pe, input int odd,
                               input int sb, input string tag, input int drop_at);
        int nb;
        nb = 9 + pe + sb;
        for (int k = 0; k < 20; k++) begin
            if (get_tx(sel) === 1'b0) break;
            step();
        end
        check({tag, "_fall"}, 32'(get_tx(sel)), 32'd0);
        if (get_tx(sel) !== 1'b0) return;
        last_fall = cyc;
        check({tag, "_latency"}, cyc - ((sel != 0) ? last_rd_b : last_rd_a), 2);
        for (int i = 0; i < nb * 4; i++) begin
            check($sformatf("%s_tx_b%0d", tag, i / 4), 32'(get_tx(sel)), 32'(exp_bit(d, pe, odd, i / 4)));
            check($sformatf("%s_done_c%0d", tag, i), 32'(get_fd(sel)), 32'(i == nb * 4 - 1));
            check($sformatf("%s_busy_c%0d", tag, i), 32'(get_busy(sel)), 32'd1);
            if (i % 4 == 2) obs_bits[i / 4] = get_tx(sel);
            if (i == drop_at) begin
                if (sel != 0) en_b = 1'b0;
                else en_a = 1'b0;
            end
            if (i == nb * 4 - 1) last_fd = cyc;
            else step();
        end
    endtask

    initial begin
        rst = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        if_a.fifo_empty = 1'b1;
        if_a.fifo_dout  = '0;
        if_b.fifo_empty = 1'b1;
        if_b.fifo_dout  = '0;

        // 1. Reset held for 3 clocks.
        repeat (3) step();
        check("rst_tx_a", 32'(tx_a), 32'd1);
        check("rst_rd_a", 32'(if_a.fifo_rd_en), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(fd_a), 32'd0);
        check("rst_tx_b", 32'(tx_b), 32'd1);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b1;
        step();
        check("idle_tx_a", 32'(tx_a), 32'd1);

        // 2. Single byte 8'hA5: 0 | 1,0,1,0,0,1,0,1 | 1.
        rd_cnt_a = 0;
        push_a(8'hA5);
        en_a = 1'b1;
        check_frame(0, 8'hA5, 0, 0, 1, "a5", -1);
        check("a5_len", last_fd - last_fall, 39);
        step();
        check("a5_after_tx", 32'(tx_a), 32'd1);
        check("a5_after_busy", 32'(busy_a), 32'd0);
        repeat (4) step();
        check("a5_rd_count", rd_cnt_a, 1);

        // 3. Back-to-back 8'h01 then 8'hFF.
        rd_cnt_a = 0;
        push_a(8'h01);
        push_a(8'hFF);
        check_frame(0, 8'h01, 0, 0, 1, "b2b_01", -1);
        prev_fd = last_fd;
        step();
        check("b2b_refetch", 32'(if_a.fifo_rd_en), 32'd1);
        check("b2b_busy_held", 32'(busy_a), 32'd1);
        check_frame(0, 8'hFF, 0, 0, 1, "b2b_ff", -1);
        check("b2b_gap", last_fall - prev_fd, 3);
        step();
        check("b2b_rd_count", rd_cnt_a, 2);
        check("b2b_idle", 32'(busy_a), 32'd0);

        // 4. Odd parity, two stop bits, byte 8'h03.
        rd_cnt_b = 0;
        push_b(8'h03);
        en_b = 1'b1;
        check_frame(1, 8'h03, 1, 1, 2, "par", -1);
        en_b = 1'b0;
        check("par_bit", 32'(obs_bits[9]), 32'd1);
        check("par_stop1", 32'(obs_bits[10]), 32'd1);
        check("par_stop2", 32'(obs_bits[11]), 32'd1);
        check("par_len", last_fd - last_fall, 47);
        step();
        check("par_after_busy", 32'(busy_b), 32'd0);
        check("par_rd_count", rd_cnt_b, 1);

        // 5. enable dropped mid-DATA with three bytes queued.
        rd_cnt_a = 0;
        push_a(8'h11);
        push_a(8'h22);
        push_a(8'h33);
        check_frame(0, 8'h11, 0, 0, 1, "drop", 20);
        for (int i = 0; i < 12; i++) begin
            step();
            check("drop_tx_idle", 32'(tx_a), 32'd1);
            check("drop_busy", 32'(busy_a), 32'd0);
        end
        check("drop_rd_count", rd_cnt_a, 1);
        check("drop_left", q_a.size(), 2);

        // 6. Reset during data bit 3 of 8'h22 (bit 3 is 0).
        rd_cnt_a = 0;
        en_a = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (tx_a === 1'b0) break;
            step();
        end
        check("rst6_fall", 32'(tx_a), 32'd0);
        repeat (16) step();
        check("rst6_bit3_before", 32'(tx_a), 32'd0);
        rst = 1'b0;
        #1;
        check("rst6_tx_now", 32'(tx_a), 32'd1);
        check("rst6_busy_now", 32'(busy_a), 32'd0);
        check("rst6_done_now", 32'(fd_a), 32'd0);
        step();
        step();
        rst = 1'b1;
        check("rst6_lost_byte", q_a.size(), 1);
        rd_cnt_a = 0;
        check_frame(0, 8'h33, 0, 0, 1, "rst6_next", -1);
        step();
        check("rst6_rd_count", rd_cnt_a, 1);

        check("rd_never_consecutive", rd_consec, 0);
        check("rd_never_on_empty", underflow, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
